// File: rtl/common_pkg.sv
// common_pkg: shared single-bit handshake level encoding.
package common_pkg;
  typedef enum logic {SIG_OFF = 1'b0, SIG_ON = 1'b1} onebit_sig_e;
endpackage

// File: rtl/debug_pkg.sv
// debug_pkg: access sizes, bridge FSM states and byte-enable constants for the debug module.
package debug_pkg;
  typedef enum logic [1:0] {AM_BYTE = 2'd0, AM_HALF = 2'd1, AM_WORD = 2'd2} am_size_e;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DONE, HOLD} sba_state_e;
  localparam logic [3:0] SBA_BE_WORD = 4'hF;
endpackage

// File: rtl/dm_sba_lane.sv
// dm_sba_lane: byte-lane steering, read extraction and alignment check for one access.
module dm_sba_lane
  import debug_pkg::*;
(
  input  logic [3:0]  st,
  input  logic [1:0]  ad,
  input  logic [31:0] di,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rext,
  output logic        misalign
);
  logic [1:0]  sz;
  logic [31:0] sh;
  assign sz = st[1:0];
  always_comb begin
    sh       = rdata >> {ad, 3'b000};
    misalign = (st > 4'd2) || (sz == AM_HALF && ad[0]) || (sz == AM_WORD && ad != 2'b00);
    be       = sz == AM_BYTE ? 4'b0001 << ad : sz == AM_HALF ? (ad[1] ? 4'b1100 : 4'b0011) : SBA_BE_WORD;
    wdata    = sz == AM_BYTE ? {4{di[7:0]}} : sz == AM_HALF ? {2{di[15:0]}} : di;
    rext     = sz == AM_BYTE ? {24'h0, sh[7:0]} : sz == AM_HALF ? {16'h0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/dm_sba_bridge.sv
// dm_sba_bridge: debug abstract memory access to req/gnt/rvalid bus, one transaction at a time.
// Optional bus watchdog under DM_SBA_TIMEOUT_EN.
module dm_sba_bridge
  import debug_pkg::*;
  import common_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              am_en_i,
  input  logic              am_wr_i,
  input  logic [3:0]        am_st_i,
  input  logic [ADDR_W-1:0] am_ad_i,
  input  logic [31:0]       am_di_i,
  output logic [31:0]       am_do_o,
  output logic              am_done_o,
  output logic              am_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i
);
  sba_state_e        state, state_n;
  logic              wr_q, bad_q, err_q, start, tmo, misalign;
  logic [3:0]        st_q, lane_st, be;
  logic [1:0]        lane_ad;
  logic [ADDR_W-1:0] ad_q;
  logic [31:0]       di_q, do_q, wdata, rext;
  assign start   = state == IDLE && am_en_i == SIG_ON;
  assign lane_st = state == IDLE ? am_st_i : st_q;
  assign lane_ad = state == IDLE ? am_ad_i[1:0] : ad_q[1:0];
  dm_sba_lane u_lane (
    .st(lane_st), .ad(lane_ad), .di(di_q), .rdata(mem_rdata_i),
    .be(be), .wdata(wdata), .rext(rext), .misalign(misalign)
  );
`ifdef DM_SBA_TIMEOUT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk_i)
    if (rst_i || state == IDLE) cnt <= '0;
    else if (state == REQ || state == WAIT_R) cnt <= cnt + 32'd1;
  assign tmo = (state == REQ || state == WAIT_R) && cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  // Illegal requests pass through WAIT_R without a bus request so completion lands two cycles after am_en_i.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? (misalign ? WAIT_R : REQ) : IDLE;
      REQ:     state_n = tmo ? DONE : mem_gnt_i ? WAIT_R : REQ;
      WAIT_R:  state_n = (bad_q || mem_rvalid_i || tmo) ? DONE : WAIT_R;
      DONE:    state_n = HOLD;
      HOLD:    state_n = am_en_i == SIG_ON ? HOLD : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      {wr_q, bad_q, err_q} <= '0;
      st_q <= '0;
      ad_q <= '0;
      di_q <= '0;
      do_q <= '0;
    end else begin
      if (start) begin
        wr_q  <= am_wr_i;
        st_q  <= am_st_i;
        ad_q  <= am_ad_i;
        di_q  <= am_di_i;
        bad_q <= misalign;
      end
      if ((state == WAIT_R && bad_q) || tmo) begin
        do_q  <= '0;
        err_q <= 1'b1;
      end else if (state == WAIT_R && mem_rvalid_i) begin
        do_q  <= (wr_q || mem_err_i) ? '0 : rext;
        err_q <= mem_err_i;
      end
    end
  assign am_do_o     = do_q;
  assign am_done_o   = state == DONE;
  assign am_err_o    = am_done_o && err_q;
  assign mem_req_o   = state == REQ;
  assign mem_we_o    = mem_req_o && wr_q;
  assign mem_be_o    = mem_req_o ? be : 4'h0;
  assign mem_addr_o  = mem_req_o ? {ad_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata_o = mem_req_o ? wdata : '0;
endmodule

// File: tb/tb_dm_sba_bridge.sv
// tb_dm_sba_bridge: directed and random transactions checked against an arithmetic lane model.
module tb_dm_sba_bridge;
  logic        clk_i = 0, rst_i = 1;
  logic        am_en_i = 0, am_wr_i = 0;
  logic [3:0]  am_st_i = 0;
  logic [31:0] am_ad_i = 0, am_di_i = 0;
  logic [31:0] am_do_o;
  logic        am_done_o, am_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0, mem_err_i = 0;
  logic [31:0] mem_rdata_i = 0;
  int tests = 0, fails = 0;

  dm_sba_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .am_en_i(am_en_i), .am_wr_i(am_wr_i), .am_st_i(am_st_i), .am_ad_i(am_ad_i), .am_di_i(am_di_i),
    .am_do_o(am_do_o), .am_done_o(am_done_o), .am_err_o(am_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] st);
    return 1 << st;
  endfunction

  function automatic bit legal(input logic [3:0] st, input logic [31:0] ad);
    return st < 3 && (ad % nbytes(st)) == 0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [3:0] st, input logic [31:0] ad);
    return 32'(((64'd1 << nbytes(st)) - 1) << (ad % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] st, input logic [31:0] di);
    longint unsigned v = 64'(di) & ((64'd1 << (8 * nbytes(st))) - 1);
    return st == 0 ? 32'(v * 64'h01010101) : st == 1 ? 32'(v * 64'h00010001) : 32'(v);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] st, input logic [31:0] ad, input logic [31:0] rd);
    longint unsigned v = 64'(rd) >> (8 * (ad % 4));
    return 32'(v & ((64'd1 << (8 * nbytes(st))) - 1));
  endfunction

  task automatic txn(input logic wr, input logic [3:0] st, input logic [31:0] ad, input logic [31:0] di,
                     input logic [31:0] rd, input logic berr, input int gdly);
    @(negedge clk_i);
    am_en_i = 1; am_wr_i = wr; am_st_i = st; am_ad_i = ad; am_di_i = di;
    if (!legal(st, ad)) begin
      @(negedge clk_i);
      chk("bad_req", {30'd0, mem_req_o, am_done_o}, 32'd0);
      @(negedge clk_i);
      chk("bad_done", {30'd0, am_done_o, am_err_o}, 32'd3);
      chk("bad_do", am_do_o, 32'd0);
    end else begin
      for (int k = 0; k <= gdly; k++) begin
        @(negedge clk_i);
        chk("req", {31'd0, mem_req_o}, 32'd1);
        chk("we", {31'd0, mem_we_o}, {31'd0, wr});
        chk("addr", mem_addr_o, {ad[31:2], 2'b00});
        chk("be", {28'd0, mem_be_o}, exp_be(st, ad));
        chk("wdata", mem_wdata_o, exp_wdata(st, di));
        mem_gnt_i = (k == gdly);
      end
      @(negedge clk_i);
      mem_gnt_i = 0;
      chk("wait", {30'd0, mem_req_o, am_done_o}, 32'd0);
      mem_rvalid_i = 1; mem_rdata_i = rd; mem_err_i = berr;
      @(negedge clk_i);
      mem_rvalid_i = 0; mem_err_i = 0;
      chk("done", {30'd0, am_done_o, am_err_o}, {30'd0, 1'b1, berr});
      chk("do", am_do_o, (wr || berr) ? 32'd0 : exp_rd(st, ad, rd));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk("hold", {30'd0, mem_req_o, am_done_o}, 32'd0);
    end
    am_en_i = 0;
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_out", {mem_req_o, mem_we_o, am_done_o, am_err_o, mem_be_o}, 32'd0);
    chk("rst_do", am_do_o, 32'd0);
    chk("rst_addr", mem_addr_o | mem_wdata_o, 32'd0);
    rst_i = 0;
    txn(1, 2, 32'h1000_0008, 32'hDEAD_BEEF, 0, 0, 0);
    txn(0, 0, 32'h0000_2003, 0, 32'hAB12_3456, 0, 0);
    chk("byte_rd", am_do_o, 32'h0000_00AB);
    txn(1, 1, 32'h0000_2002, 32'h0000_55AA, 0, 0, 0);
    txn(1, 1, 32'h0000_2002, 32'h0000_55AA, 0, 0, 4);
    txn(0, 2, 32'h0000_2001, 0, 0, 0, 0);
    txn(0, 3, 32'h0000_2000, 0, 0, 0, 0);
    txn(0, 2, 32'h0000_3000, 0, 32'h1234_5678, 1, 1);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ad = $urandom;
      logic [3:0] st = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) ad = ad & ~32'(nbytes(st) - 1);
      txn(1'($urandom), st, ad, $urandom, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end
    @(negedge clk_i);
    am_en_i = 1; am_wr_i = 0; am_st_i = 2; am_ad_i = 32'h40; mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    mem_gnt_i = 1;
    @(negedge clk_i);
    mem_gnt_i = 0; rst_i = 1; am_en_i = 0;
    @(negedge clk_i);
    rst_i = 0;
    chk("rst_mid_req", {31'd0, mem_req_o}, 32'd0);
    mem_rvalid_i = 1;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    chk("stray_rv", {30'd0, am_done_o, mem_req_o}, 32'd0);
    @(negedge clk_i);
    chk("stray_rv2", {31'd0, am_done_o}, 32'd0);
    chk("stray_do", am_do_o, 32'd0);
`ifdef DM_SBA_TIMEOUT_EN
    @(negedge clk_i);
    am_en_i = 1; am_wr_i = 1; am_st_i = 2; am_ad_i = 32'h80;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      chk("tmo_req", {31'd0, mem_req_o}, 32'd1);
    end
    @(negedge clk_i);
    chk("tmo_done", {29'd0, am_done_o, am_err_o, mem_req_o}, 32'd6);
    chk("tmo_do", am_do_o, 32'd0);
    am_en_i = 0;
    @(negedge clk_i);
    mem_rvalid_i = 1;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    @(negedge clk_i);
    chk("tmo_stray", {31'd0, am_done_o}, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
